pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the five-stage core (IF/ID/EX/MEM/WB). It owns the per-stage valid bits and produces the load enables for the ID/EX/MEM/WB pipeline registers, including the MEM→WB register that carries `mem_valid`/`wr_valid`. It applies three kinds of control:
- stalls for load-use hazards;
- holds a multi-cycle multiply in EX;
- flushes younger instructions when cp0 redirects the PC from MEM (exception or eret).

## Interface
Parameters:
- `MUL_CYCLES`, default 4: cycles a multiply occupies EX. Legal range is ≥2.

Ports:
- `Clk`  in  1: pipeline clock. All state updates on the negedge, matching the pipeline registers.
- `resetn`  in  1: reset, synchronous and active-low.
- `if_valid`  in  1: the fetch stage holds an instruction.
- `id_hazard`  in  1: ID cannot issue (load-use). Ignored when ID is not valid.
- `ex_is_mul`  in  1: the EX instruction is mult/multu.
- `mem_redirect`  in  1: the MEM instruction raised an exception or is an eret (from cp0 decode).
- `id_valid`, `ex_valid`, `mem_valid`, `wr_valid`  out  1 each: stage valid bits.
- `id_allowin`  out  1: fetch may hand over an instruction; it also enables the PC/IF→ID register.
- `ex_en`, `mem_en`, `wr_en`  out  1 each: load enables for the ID→EX, EX→MEM and MEM→WB registers.
- `flush`  out  1: one-cycle pulse; IF discards its instruction and takes the cp0 PC.
- `mul_start`  out  1: one-cycle pulse on the first EX cycle of a valid multiply.
- `mul_busy`  out  1: a multiply is in progress and not yet complete.

## Operation
- **Ready-go signals:**
  - `rg_id = !id_hazard`
  - `rg_ex = !ex_is_mul || (state==MBUSY && cnt==0)`
  - `rg_mem = 1`
  - `rg_wr = 1`
- **Allow-in chain:**
  - `wr_allowin = 1`
  - for each stage k, `allowin_k = !v_k || (rg_k && allowin_{k+1})`
- **Enables:** `id_allowin = allowin_id`, `ex_en = allowin_ex`, `mem_en = allowin_mem`, `wr_en = 1`.
- **Valid update (no redirect):** when `allowin_k`, `v_k <= v_{k-1} && rg_{k-1}` (with `v_if = if_valid`); otherwise `v_k` holds.
- **Redirect:** when `mem_redirect && mem_valid`:
  - `wr_valid <= 1`. The faulting instruction reaches WB so cp0 records EPC/status.
  - `id_valid`, `ex_valid` and `mem_valid` are cleared to 0.
  - `flush = 1` in that cycle.
  - Any multiply in progress is aborted: state goes to IDLE and `cnt` to 0.
- **Multiply FSM:** states IDLE, MBUSY; counter `cnt` of width clog2(MUL_CYCLES).
  - IDLE, `ex_valid && ex_is_mul`: `mul_start = 1`, go to MBUSY with `cnt = MUL_CYCLES-2`.
  - MBUSY, `cnt != 0`: decrement `cnt`.
  - MBUSY, `cnt == 0`: `rg_ex = 1`. Return to IDLE only when `allowin_mem` is true; otherwise hold MBUSY with `cnt = 0`.
  - `mul_busy = (ex_valid && ex_is_mul) && !rg_ex`.
- **Simultaneous events:**
  - Redirect overrides hazard, multiply and fetch updates in the same cycle.
  - `id_hazard` while `ex_en = 0` produces no extra effect.
  - With `if_valid = 1` and `id_allowin = 1` on a redirect cycle, `id_valid` is still 0.

## Timing
- **Reset:** all valid bits are 0, state is IDLE and `cnt` is 0. Outputs then read:
  - `id_allowin`, `ex_en`, `mem_en`, `wr_en` = 1
  - `flush`, `mul_start`, `mul_busy` = 0
- **Reset mid-operation:** identical result. The multiply is dropped and the pipe is emptied on the sampling edge.
- **Output timing:** all outputs are combinational from the current state and inputs, settling within the cycle before the negedge that consumes them.
- **Throughput and latency:**
  - With no stalls, one instruction per cycle and 4 edges from IF to WB.
  - A multiply occupies EX for exactly MUL_CYCLES cycles when MEM is free.
- **Load-use stall:** `id_hazard` held for N cycles adds N bubbles; the `ex_valid` bubble enters the cycle after.
- **Flush penalty:** exactly 3 bubbles (ID, EX, MEM cleared).

## Structure
- **Shared package `pipe_pkg`:**
  - enum `mul_state_t` {IDLE, MBUSY}
  - `localparam MUL_CNT_W = $clog2(MUL_CYCLES)`
  - stage index constants ID/EX/MEM/WB
- **Sub-module `mul_seq`:** the multiply FSM and counter.
  - Inputs: `Clk`, `resetn`, `ex_valid`, `ex_is_mul`, `allowin_mem`, `abort`.
  - Outputs: `rg_ex`, `mul_start`, `mul_busy`.
- **Top level:** the valid/allow-in chain and the redirect logic.

## Test plan
- **Reset then stream:** reset then 6 consecutive `if_valid` with no hazards → `wr_valid` goes high 4 edges after the first, then stays high for 6 cycles; all enables are 1 throughout.
- **Load-use stall:** `id_hazard` for 2 cycles with a valid ID → `id_allowin = 0` for 2 cycles, `ex_valid = 0` for 2 cycles, and the ID instruction reaches EX on the third edge.
- **Multiply, MUL_CYCLES=4:** `ex_is_mul` valid → `mul_start` pulses in cycle 1, `mul_busy = 1` for cycles 1–3, `ex_en = 0` for cycles 1–3, and `mem_valid` rises after cycle 4.
- **Redirect mid-multiply:** `mem_redirect` while a multiply is in MBUSY with `cnt = 1` → next edge gives `wr_valid = 1`, `id`/`ex`/`mem_valid = 0`, state IDLE; `flush` is 1 for exactly 1 cycle.
- **Redirect with hazard:** `mem_redirect` and `id_hazard` in the same cycle → the flush wins and `id_valid = 0` next cycle.
- **Reset mid-multiply:** `resetn = 0` during MBUSY → after the edge, all valids are 0, `mul_busy = 0` and `id_allowin = 1`.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the five-stage pipeline sequencing controller.
package pipe_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    MBUSY = 1'b1
  } mul_state_t;

  localparam int unsigned MUL_CYCLES_DFLT = 4;
  localparam int unsigned MUL_CNT_W       = $clog2(MUL_CYCLES_DFLT);

  localparam int unsigned STG_ID  = 0;
  localparam int unsigned STG_EX  = 1;
  localparam int unsigned STG_MEM = 2;
  localparam int unsigned STG_WB  = 3;

endpackage

// File: rtl/mul_seq.sv
// Multiply sequencer: keeps a mult/multu in EX for MUL_CYCLES cycles and
// releases it into MEM once the count has run out.
module mul_seq
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DFLT,
  parameter int unsigned CNT_W      = MUL_CNT_W
) (
  input  logic Clk,
  input  logic resetn,
  input  logic ex_valid,
  input  logic ex_is_mul,
  input  logic allowin_mem,
  input  logic abort,
  output logic rg_ex,
  output logic mul_start,
  output logic mul_busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mul_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_done;

  always_ff @(negedge Clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    mul_start   = 1'b0;
    w_done      = (r_state == MBUSY) && (r_cnt == '0);
    rg_ex       = !ex_is_mul || w_done;
    unique case (r_state)
      IDLE: begin
        if (ex_valid && ex_is_mul) begin
          mul_start   = 1'b1;
          w_state_nxt = MBUSY;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      MBUSY: begin
        // Finished multiply waits in MBUSY with cnt at 0 until MEM can take it.
        if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_ONE;
        else if (allowin_mem) w_state_nxt = IDLE;
      end
    endcase
    if (abort) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end
    mul_busy = ex_valid && ex_is_mul && !rg_ex;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage valid bits, allow-in chain, load
// enables, load-use stall, multiply hold and cp0 redirect flush.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DFLT
) (
  input  logic Clk,
  input  logic resetn,
  input  logic if_valid,
  input  logic id_hazard,
  input  logic ex_is_mul,
  input  logic mem_redirect,
  output logic id_valid,
  output logic ex_valid,
  output logic mem_valid,
  output logic wr_valid,
  output logic id_allowin,
  output logic ex_en,
  output logic mem_en,
  output logic wr_en,
  output logic flush,
  output logic mul_start,
  output logic mul_busy
);

  logic [STG_WB:STG_ID] r_valid, w_valid_nxt;
  logic w_rg_id, w_rg_ex, w_rg_mem;
  logic w_allowin_id, w_allowin_ex, w_allowin_mem, w_allowin_wr;
  logic w_redirect;

  assign w_rg_id       = !id_hazard;
  assign w_rg_mem      = 1'b1;
  assign w_allowin_wr  = 1'b1;
  assign w_allowin_mem = !r_valid[STG_MEM] || (w_rg_mem && w_allowin_wr);
  assign w_allowin_ex  = !r_valid[STG_EX]  || (w_rg_ex  && w_allowin_mem);
  assign w_allowin_id  = !r_valid[STG_ID]  || (w_rg_id  && w_allowin_ex);
  assign w_redirect    = mem_redirect && r_valid[STG_MEM];

  mul_seq #(
    .MUL_CYCLES (MUL_CYCLES),
    .CNT_W      ($clog2(MUL_CYCLES))
  ) u_mul_seq (
    .Clk         (Clk),
    .resetn      (resetn),
    .ex_valid    (r_valid[STG_EX]),
    .ex_is_mul   (ex_is_mul),
    .allowin_mem (w_allowin_mem),
    .abort       (w_redirect),
    .rg_ex       (w_rg_ex),
    .mul_start   (mul_start),
    .mul_busy    (mul_busy)
  );

  always_comb begin
    w_valid_nxt = r_valid;
    if (w_allowin_id)  w_valid_nxt[STG_ID]  = if_valid;
    if (w_allowin_ex)  w_valid_nxt[STG_EX]  = r_valid[STG_ID] && w_rg_id;
    if (w_allowin_mem) w_valid_nxt[STG_MEM] = r_valid[STG_EX] && w_rg_ex;
    if (w_allowin_wr)  w_valid_nxt[STG_WB]  = r_valid[STG_MEM];
    // Faulting instruction still retires into WB so cp0 can latch EPC/status.
    if (w_redirect) begin
      w_valid_nxt         = '0;
      w_valid_nxt[STG_WB] = 1'b1;
    end
  end

  always_ff @(negedge Clk) begin
    if (!resetn) r_valid <= '0;
    else         r_valid <= w_valid_nxt;
  end

  assign id_valid   = r_valid[STG_ID];
  assign ex_valid   = r_valid[STG_EX];
  assign mem_valid  = r_valid[STG_MEM];
  assign wr_valid   = r_valid[STG_WB];
  assign id_allowin = w_allowin_id;
  assign ex_en      = w_allowin_ex;
  assign mem_en     = w_allowin_mem;
  assign wr_en      = w_allowin_wr;
  assign flush      = w_redirect;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: cycle table with hand-derived expectations
// routed through a scoreboard, plus hand-written multi-cycle sequences.
module tb_pipe_ctrl;

  logic Clk;
  logic resetn, if_valid, id_hazard, ex_is_mul, mem_redirect;
  logic id_valid, ex_valid, mem_valid, wr_valid;
  logic id_allowin, ex_en, mem_en, wr_en, flush, mul_start, mul_busy;

  logic b_rstn, b_ifv, b_haz, b_mul, b_redir;
  logic b_idv, b_exv, b_memv, b_wrv, b_ida, b_exen, b_memen, b_wren, b_flush, b_ms, b_mb;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  pipe_ctrl #(.MUL_CYCLES(4)) dut (
    .Clk(Clk), .resetn(resetn), .if_valid(if_valid), .id_hazard(id_hazard),
    .ex_is_mul(ex_is_mul), .mem_redirect(mem_redirect),
    .id_valid(id_valid), .ex_valid(ex_valid), .mem_valid(mem_valid), .wr_valid(wr_valid),
    .id_allowin(id_allowin), .ex_en(ex_en), .mem_en(mem_en), .wr_en(wr_en),
    .flush(flush), .mul_start(mul_start), .mul_busy(mul_busy)
  );

  pipe_ctrl #(.MUL_CYCLES(2)) dut2 (
    .Clk(Clk), .resetn(b_rstn), .if_valid(b_ifv), .id_hazard(b_haz),
    .ex_is_mul(b_mul), .mem_redirect(b_redir),
    .id_valid(b_idv), .ex_valid(b_exv), .mem_valid(b_memv), .wr_valid(b_wrv),
    .id_allowin(b_ida), .ex_en(b_exen), .mem_en(b_memen), .wr_en(b_wren),
    .flush(b_flush), .mul_start(b_ms), .mul_busy(b_mb)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [10:0] w_obs;
  assign w_obs = {id_valid, ex_valid, mem_valid, wr_valid,
                  id_allowin, ex_en, mem_en, wr_en, flush, mul_start, mul_busy};

  typedef struct {
    logic [4:0]  in;   // {resetn, if_valid, id_hazard, ex_is_mul, mem_redirect}
    logic [10:0] exp;  // {id,ex,mem,wr valid, id_allowin, ex_en, mem_en, wr_en, flush, mul_start, mul_busy}
    logic [10:0] msk;
  } vec_t;

  typedef struct {
    logic [10:0] exp;
    logic [10:0] msk;
    int unsigned idx;
  } sb_t;

  localparam logic [10:0] ALL = 11'h7FF;

  vec_t tbl[$];
  sb_t  sb[$];

  task automatic add(input logic [4:0] in, input logic [10:0] exp, input logic [10:0] msk);
    vec_t v;
    v.in = in; v.exp = exp; v.msk = msk;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    sb_t e;
    int unsigned n;

    // stream of six
    add(5'b11000, 11'b0000_1111_000, ALL);
    add(5'b11000, 11'b1000_1111_000, ALL);
    add(5'b11000, 11'b1100_1111_000, ALL);
    add(5'b11000, 11'b1110_1111_000, ALL);
    add(5'b11000, 11'b1111_1111_000, ALL);
    add(5'b11000, 11'b1111_1111_000, ALL);
    add(5'b10000, 11'b1111_1111_000, ALL);
    add(5'b10000, 11'b0111_1111_000, ALL);
    add(5'b10000, 11'b0011_1111_000, ALL);
    add(5'b10000, 11'b0001_1111_000, ALL);
    add(5'b10000, 11'b0000_1111_000, ALL);
    // load-use stall, two cycles
    add(5'b11000, 11'b0000_1111_000, ALL);
    add(5'b11100, 11'b1000_0111_000, ALL);
    add(5'b11100, 11'b1000_0111_000, ALL);
    add(5'b11000, 11'b1000_1111_000, ALL);
    add(5'b10000, 11'b1100_1111_000, ALL);
    add(5'b10000, 11'b0110_1111_000, ALL);
    add(5'b10000, 11'b0011_1111_000, ALL);
    add(5'b10000, 11'b0001_1111_000, ALL);
    // multiply with a younger instruction held in ID
    add(5'b11000, 11'b0000_1111_000, ALL);
    add(5'b11000, 11'b1000_1111_000, ALL);
    add(5'b10010, 11'b1100_0011_011, ALL);
    add(5'b10010, 11'b1100_0011_001, ALL);
    add(5'b10010, 11'b1100_0011_001, ALL);
    add(5'b10010, 11'b1100_1111_000, ALL);
    add(5'b10000, 11'b0110_1111_000, ALL);
    add(5'b10000, 11'b0011_1111_000, ALL);
    add(5'b10000, 11'b0001_1111_000, ALL);
    // redirect on the first multiply cycle, then a fresh multiply must restart
    add(5'b11000, 11'b0000_1111_000, ALL);
    add(5'b11000, 11'b1000_1111_000, ALL);
    add(5'b11000, 11'b1100_1111_000, ALL);
    add(5'b11011, 11'b1110_0011_100, 11'b1111_1111_100);
    add(5'b10000, 11'b0001_1111_000, ALL);
    add(5'b11000, 11'b0000_1111_000, ALL);
    add(5'b10000, 11'b1000_1111_000, ALL);
    add(5'b10010, 11'b0100_1011_011, ALL);
    add(5'b10011, 11'b0100_1011_001, ALL);
    add(5'b10011, 11'b0100_1011_001, ALL);
    add(5'b10010, 11'b0100_1111_000, ALL);
    add(5'b10000, 11'b0010_1111_000, ALL);
    add(5'b10000, 11'b0001_1111_000, ALL);
    // redirect together with a hazard
    add(5'b11000, 11'b0000_1111_000, ALL);
    add(5'b11000, 11'b1000_1111_000, ALL);
    add(5'b11000, 11'b1100_1111_000, ALL);
    add(5'b11101, 11'b1110_0111_100, ALL);
    add(5'b11100, 11'b0001_1111_000, ALL);
    add(5'b10000, 11'b1000_1111_000, ALL);
    add(5'b10000, 11'b0100_1111_000, ALL);
    add(5'b10000, 11'b0010_1111_000, ALL);
    add(5'b10000, 11'b0001_1111_000, ALL);
    // redirect while fetch hands over with id_allowin high
    add(5'b11000, 11'b0000_1111_000, ALL);
    add(5'b11000, 11'b1000_1111_000, ALL);
    add(5'b10000, 11'b1100_1111_000, ALL);
    add(5'b11001, 11'b0110_1111_100, ALL);
    add(5'b10000, 11'b0001_1111_000, ALL);
    // reset during MBUSY, then a multiply from IDLE again
    add(5'b11000, 11'b0000_1111_000, ALL);
    add(5'b11000, 11'b1000_1111_000, ALL);
    add(5'b10010, 11'b1100_0011_011, ALL);
    add(5'b00010, 11'b1100_0011_001, ALL);
    add(5'b10010, 11'b0000_1111_000, ALL);
    add(5'b11000, 11'b0000_1111_000, ALL);
    add(5'b10000, 11'b1000_1111_000, ALL);
    add(5'b10010, 11'b0100_1011_011, ALL);
    add(5'b10010, 11'b0100_1011_001, ALL);
    add(5'b10010, 11'b0100_1011_001, ALL);
    add(5'b10010, 11'b0100_1111_000, ALL);
    add(5'b10000, 11'b0010_1111_000, ALL);
    add(5'b10000, 11'b0001_1111_000, ALL);

    resetn = 1'b0; if_valid = 1'b0; id_hazard = 1'b0; ex_is_mul = 1'b0; mem_redirect = 1'b0;
    b_rstn = 1'b0; b_ifv = 1'b0; b_haz = 1'b0; b_mul = 1'b0; b_redir = 1'b0;
    repeat (2) @(negedge Clk);
    @(posedge Clk); #1;
    chk("reset", 32'(w_obs), 32'(11'b0000_1111_000));

    for (int unsigned i = 0; i < tbl.size(); i++) begin
      @(posedge Clk);
      {resetn, if_valid, id_hazard, ex_is_mul, mem_redirect} = tbl[i].in;
      e.exp = tbl[i].exp; e.msk = tbl[i].msk; e.idx = i;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      chk($sformatf("row%0d", e.idx), 32'(w_obs & e.msk), 32'(e.exp & e.msk));
    end

    // IF-to-WB latency, bounded wait
    @(posedge Clk); if_valid = 1'b1;
    @(negedge Clk); n = 1;
    #1 if_valid = 1'b0;
    while (!wr_valid && n < 10) begin
      @(negedge Clk); #1; n++;
    end
    chk("latency", 32'(n), 32'd4);

    // reset with a full pipe
    repeat (4) begin @(posedge Clk); if_valid = 1'b1; end
    @(posedge Clk); resetn = 1'b0; #1;
    chk("full_pre", 32'({id_valid, ex_valid, mem_valid, wr_valid}), 32'(4'b1111));
    @(negedge Clk); #1;
    chk("full_rst", 32'({id_valid, ex_valid, mem_valid, wr_valid, id_allowin, mul_busy}), 32'(6'b0000_10));
    @(posedge Clk); resetn = 1'b1; if_valid = 1'b0;

    // MUL_CYCLES=2: one-bit counter loaded with 0
    @(posedge Clk); b_rstn = 1'b1; b_ifv = 1'b1;
    @(posedge Clk); b_ifv = 1'b0;
    @(posedge Clk); b_mul = 1'b1; #1;
    chk("m2_start", 32'({b_ms, b_mb, b_exen}), 32'(3'b110));
    @(posedge Clk); #1;
    chk("m2_done", 32'({b_ms, b_mb, b_exen}), 32'(3'b001));
    @(negedge Clk); #1; b_mul = 1'b0;
    chk("m2_mem", 32'({b_exv, b_memv}), 32'(2'b01));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
